// File: rtl/sound_effects.sv
// Prioritised square-wave sound effect generator driven by physics event pulses.
// One tone (or the two-segment ball-lost sequence) plays at a time; higher or equal rank preempts.
module sound_effects #(
  parameter int unsigned DIV_WALL       = 113636,
  parameter int unsigned DIV_PADDLE     = 56818,
  parameter int unsigned DIV_BLOCK_BASE = 28409,
  parameter int unsigned DIV_BLOCK_STEP = 2000,
  parameter int unsigned DIV_LOST_HI    = 75757,
  parameter int unsigned DIV_LOST_LO    = 151515,
  parameter int unsigned TONE_CYCLES    = 2500000,
  parameter int unsigned LOST_CYCLES    = 10000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       HIT_WALL,
  input  logic       HIT_PADDLE,
  input  logic       HIT_BLOCK,
  input  logic [2:0] HIT_BLOCK_ROW,
  input  logic       BALL_LOST,
  input  logic       MUTE,
  output logic       SPEAKER,
  output logic       BUSY
);

  typedef enum logic [1:0] {StIdle, StTone, StLostHi, StLostLo} stateT;

  stateT       stateQ, stateD;
  logic [2:0]  rankQ, rankD;
  logic [17:0] divQ, divD;
  logic [17:0] halfCntQ, halfCntD;
  logic [23:0] durCntQ, durCntD;
  logic        phaseQ, phaseD;

  logic [2:0]  candRank;
  logic [17:0] candDiv;
  logic [23:0] candDur;
  logic        take;

  always_comb begin
    candRank = 3'd0;
    candDiv  = 18'd0;
    candDur  = 24'(TONE_CYCLES);
    if (BALL_LOST) begin
      candRank = 3'd4;
      candDiv  = 18'(DIV_LOST_HI);
      candDur  = 24'(LOST_CYCLES);
    end else if (HIT_BLOCK) begin
      candRank = 3'd3;
      candDiv  = 18'(DIV_BLOCK_BASE) + 18'(HIT_BLOCK_ROW) * 18'(DIV_BLOCK_STEP);
    end else if (HIT_PADDLE) begin
      candRank = 3'd2;
      candDiv  = 18'(DIV_PADDLE);
    end else if (HIT_WALL) begin
      candRank = 3'd1;
      candDiv  = 18'(DIV_WALL);
    end
  end

  // The ball-lost sequence is uninterruptible, so only IDLE and TONE accept events.
  assign take = (stateQ == StIdle || stateQ == StTone) && candRank != 3'd0 && candRank >= rankQ;

  always_comb begin
    stateD   = stateQ;
    rankD    = rankQ;
    divD     = divQ;
    halfCntD = halfCntQ;
    durCntD  = durCntQ;
    phaseD   = phaseQ;

    if (stateQ != StIdle) begin
      if (halfCntQ == 18'd1) begin
        halfCntD = divQ;
        phaseD   = ~phaseQ;
      end else begin
        halfCntD = halfCntQ - 18'd1;
      end
      durCntD = durCntQ - 24'd1;
    end

    if (take) begin
      stateD   = (candRank == 3'd4) ? StLostHi : StTone;
      rankD    = candRank;
      divD     = candDiv;
      halfCntD = candDiv;
      durCntD  = candDur;
      phaseD   = 1'b1;
    end else if (stateQ != StIdle && durCntQ == 24'd1) begin
      if (stateQ == StLostHi) begin
        stateD   = StLostLo;
        divD     = 18'(DIV_LOST_LO);
        halfCntD = 18'(DIV_LOST_LO);
        durCntD  = 24'(LOST_CYCLES);
        phaseD   = 1'b1;
      end else begin
        stateD   = StIdle;
        rankD    = 3'd0;
        divD     = 18'd0;
        halfCntD = 18'd0;
        durCntD  = 24'd0;
        phaseD   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stateQ   <= StIdle;
      rankQ    <= 3'd0;
      divQ     <= 18'd0;
      halfCntQ <= 18'd0;
      durCntQ  <= 24'd0;
      phaseQ   <= 1'b0;
      SPEAKER  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      rankQ    <= rankD;
      divQ     <= divD;
      halfCntQ <= halfCntD;
      durCntQ  <= durCntD;
      phaseQ   <= phaseD;
      SPEAKER  <= phaseD & ~MUTE;
      BUSY     <= (stateD != StIdle);
    end
  end

endmodule
